mem_stall_resp: RTL and testbench
=================================

# mem_stall_resp

Multi-cycle memory responder: the target end of the processor's instruction/data memory interface (Addr/DataIn/Rd/Wr in, DataOut/Done/Stall out). Accepts one word request at a time, holds the pipeline with Stall for a fixed programmable latency, then performs the access and pulses Done with read data. It replaces the single-cycle memories behind the fetch and mem stages in the stalling-memory build of the pipeline.

## Interface
- DEPTH_LOG2, 8: log2 of word count (256 x 16-bit words).
- LATENCY, 4: BUSY cycles per access; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- Addr  in  16  byte address; bit 0 must be 0.
- DataIn  in  16  write data.
- Rd  in  1  read request.
- Wr  in  1  write request.
- DataOut  out  16  read data, valid only while Done=1.
- Done  out  1  one-cycle completion pulse.
- Stall  out  1  requester must hold and not advance.
- err  out  1  one-cycle pulse for an illegal request.

## Operation
- States: IDLE, BUSY, DONE (2-bit encoded); 4-bit down-counter cnt.
- IDLE: a request is present when Rd|Wr. A legal request has Rd^Wr and Addr[0]=0.
  - Legal: the block latches op, word index Addr[DEPTH_LOG2:1], and DataIn; sets cnt=LATENCY-1; moves to BUSY.
  - Illegal (Rd&Wr, or odd Addr): err<=1 next cycle; no access; stays IDLE.
- BUSY: cnt!=0 decrements cnt. cnt==0 moves to DONE.
  - On that same edge: a write stores the latched data; a read loads the array word into DataOut.
  - Rd/Wr/Addr/DataIn are ignored throughout BUSY because all request fields are latched.
- DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
  - A request in DONE is not accepted. The requester re-presents it and it is accepted in the following IDLE cycle.
- Address upper bits above DEPTH_LOG2 are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes.
- A read always returns the value of the most recent completed write to that word.
- Memory contents are not cleared by rst. The contents of an unwritten word are undefined.
- Stall (combinational) = (state==BUSY) | (state==IDLE & legal request). Stall is 0 in DONE, and 0 for illegal requests.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, Done=0, err=0, DataOut=0, Stall follows its equation.
- Reset during BUSY: the access is abandoned and no write occurs. Reset during DONE: Done drops immediately.
- Request presented in cycle 0 (IDLE):
  - Stall=1 in cycles 0..LATENCY.
  - Done=1 and Stall=0 in cycle LATENCY+1.
  - Earliest next acceptance is cycle LATENCY+2.
- LATENCY=1: request in cycle 0, BUSY in cycle 1, Done in cycle 2.
- Done, DataOut and err are registered outputs.
- DataOut holds its last value outside DONE; it is not cleared, and the requester samples it only while Done=1.
- err=1 in cycle 1 for an illegal request in cycle 0. Back-to-back illegal requests give consecutive err pulses.
- Write latency equals read latency. Done also pulses for writes, with DataOut unchanged.

## Structure
- Package mem_resp_pkg holds:
  - the state typedef (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - the op encoding (OP_RD, OP_WR);
  - the LATENCY bound constant (15).
- Sub-module mem_resp_array: 2^DEPTH_LOG2 x 16 storage with a single synchronous port (we, idx, wdata, rdata captured on clk). It has no reset.
- The top level holds the FSM, counter, request latches, and Stall/err logic.

## Test plan
- LATENCY=4: Wr Addr=0x0010 DataIn=0xBEEF in cycle 0, then Rd Addr=0x0010 when accepted.
  - Write: Stall=1 for cycles 0-4 and Done in cycle 5.
  - Read: Done 5 cycles after acceptance, with DataOut=0xBEEF.
- Odd address: Rd Addr=0x0011 gives err=1 in the next cycle, Stall=0, no Done, and the state remains IDLE.
- Rd=Wr=1, Addr=0x0020: err pulse, and a later read of 0x0020 returns the previously written value, unchanged.
- Aliasing (DEPTH_LOG2=8):
  - Write 0x1234 to 0x0202.
  - A read of 0x0002 returns 0x1234.
  - Changing Addr/DataIn mid-BUSY has no effect.
- Reset mid-operation:
  - Start Wr 0x0040 = 0x5555 over prior content 0xAAAA.
  - Assert rst in BUSY; Stall and Done drop immediately.
  - A subsequent read of 0x0040 returns 0xAAAA.
- LATENCY=1 back-to-back: three reads held continuously give Done in cycles 2, 5 and 8, with no request dropped and no Done while Stall=1.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the stalling memory responder.
package mem_resp_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Counter preload for a given latency, clamped into the supported 1..15 range.
  function automatic logic [CNT_W-1:0] lat_init(input int unsigned lat);
    if (lat < 1) return '0;
    if (lat > LATENCY_MAX) return CNT_W'(LATENCY_MAX - 1);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_stall_resp_if.sv
// Requester/responder memory handshake bundle.
interface mem_stall_resp_if;
  import mem_resp_pkg::*;

  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] DataIn;
  logic              Rd;
  logic              Wr;
  logic [DATA_W-1:0] DataOut;
  logic              Done;
  logic              Stall;
  logic              err;

  modport master (
    output Addr, DataIn, Rd, Wr,
    input  DataOut, Done, Stall, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr,
    output DataOut, Done, Stall, err
  );

endinterface

// File: rtl/mem_resp_array.sv
// Word storage with one synchronous read/write port; contents survive reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first port: rdata shows the word as it was before any same-edge write.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_stall_resp.sv
// Multi-cycle memory target: latches one request, stalls for LATENCY cycles,
// then performs the access and pulses Done.
module mem_stall_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 4
) (
  input logic             clk,
  input logic             rst,
  mem_stall_resp_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = lat_init(LATENCY);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  op_t                   op_q, op_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DEPTH_LOG2-1:0] arr_idx;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic [DATA_W-1:0]     rdata;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  we;
  logic                  req;
  logic                  legal;
  logic                  unused_addr;

  // Request decode: exactly one of Rd/Wr and a halfword-aligned address.
  assign req   = bus.Rd | bus.Wr;
  assign legal = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];

  // Upper address bits alias and are intentionally dropped.
  assign unused_addr = ^bus.Addr[ADDR_W-1:DEPTH_LOG2+1];

  mem_resp_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .idx  (arr_idx),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  // State, counter and request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, access strobes and registered-output next values.
  // The array is addressed from the live request in IDLE so its read
  // register already holds the target word by the final BUSY edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    arr_idx = idx_q;
    case (state_q)
      IDLE: begin
        arr_idx = bus.Addr[DEPTH_LOG2:1];
        if (legal) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          op_d    = bus.Wr ? OP_WR : OP_RD;
          idx_d   = bus.Addr[DEPTH_LOG2:1];
          wdata_d = bus.DataIn;
        end else if (req) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          we      = (op_q == OP_WR);
          if (op_q == OP_RD) dout_d = rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall covers the accepting cycle and every BUSY cycle.
  assign bus.Stall   = (state_q == BUSY) | ((state_q == IDLE) & legal);
  assign bus.Done    = done_q;
  assign bus.err     = err_q;
  assign bus.DataOut = dout_q;

endmodule

// File: tb/tb_mem_stall_resp.sv
// Directed scoreboard bench for mem_stall_resp (LATENCY=4 and LATENCY=1 instances).
module tb_mem_stall_resp;
  import mem_resp_pkg::*;

  localparam int unsigned LAT4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_stall_resp_if bus4();
  mem_stall_resp_if bus1();

  mem_stall_resp #(.DEPTH_LOG2(8), .LATENCY(LAT4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  mem_stall_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m4 [256];
  logic [15:0] m1 [256];
  logic [15:0] last4;

  function automatic logic [7:0] widx(input logic [15:0] a);
    return a[8:1];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the LATENCY=4 instance.
  task automatic req4(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] data, input bit scramble);
    int n;
    logic [15:0] e;
    bus4.Rd = rd; bus4.Wr = wr; bus4.Addr = addr; bus4.DataIn = data;
    if (rd) exp_q.push_back(m4[widx(addr)]);
    else    m4[widx(addr)] = data;
    #1 chk("req_stall", 16'(bus4.Stall), 16'd1);
    n = 0;
    do begin
      cyc();
      n++;
      if (scramble) begin
        bus4.Addr = 16'($urandom);
        bus4.DataIn = 16'($urandom);
      end
      #1;
      if (bus4.Done !== 1'b1) chk("busy_stall", 16'(bus4.Stall), 16'd1);
    end while (bus4.Done !== 1'b1 && n < 20);
    chk("done_latency", 16'(n), 16'(LAT4 + 1));
    chk("done_stall", 16'(bus4.Stall), 16'd0);
    if (bus4.Done === 1'b1) begin
      if (rd) begin
        e = exp_q.pop_front();
        chk("rd_data", bus4.DataOut, e);
        last4 = e;
      end else begin
        chk("wr_dout_hold", bus4.DataOut, last4);
      end
    end
    bus4.Rd = 1'b0; bus4.Wr = 1'b0;
    cyc();
    chk("done_pulse", 16'(bus4.Done), 16'd0);
  endtask

  // Three requests held continuously on the LATENCY=1 instance.
  task automatic b2b1(input logic wr, input logic [15:0] base);
    int k;
    logic [15:0] a;
    logic [15:0] e;
    k = 0;
    a = base;
    bus1.Rd = ~wr; bus1.Wr = wr; bus1.Addr = a; bus1.DataIn = a ^ 16'h5A5A;
    if (wr) m1[widx(a)] = a ^ 16'h5A5A;
    else    exp_q.push_back(m1[widx(a)]);
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("b2b_overlap", 16'(bus1.Done & bus1.Stall), 16'd0);
      if (bus1.Done === 1'b1) begin
        chk("b2b_done_cycle", 16'(c), 16'(2 + 3 * k));
        if (!wr && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("b2b_rd_data", bus1.DataOut, e);
        end
        k++;
        if (k < 3) begin
          a = base + 16'(2 * k);
          bus1.Addr = a; bus1.DataIn = a ^ 16'h5A5A;
          if (wr) m1[widx(a)] = a ^ 16'h5A5A;
          else    exp_q.push_back(m1[widx(a)]);
        end else begin
          bus1.Rd = 1'b0; bus1.Wr = 1'b0;
        end
      end
      cyc();
    end
    chk("b2b_count", 16'(k), 16'd3);
  endtask

  initial begin
    bus4.Rd = 1'b0; bus4.Wr = 1'b0; bus4.Addr = '0; bus4.DataIn = '0;
    bus1.Rd = 1'b0; bus1.Wr = 1'b0; bus1.Addr = '0; bus1.DataIn = '0;
    last4 = 16'h0000;

    // Reset values
    #2;
    chk("rst_done", 16'(bus4.Done), 16'd0);
    chk("rst_err", 16'(bus4.err), 16'd0);
    chk("rst_dout", bus4.DataOut, 16'h0000);
    chk("rst_stall", 16'(bus4.Stall), 16'd0);
    chk("rst_done1", 16'(bus1.Done), 16'd0);
    @(negedge clk) rst = 1'b0;
    cyc();

    // Basic write then read
    req4(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    req4(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    // Odd address read
    bus4.Rd = 1'b1; bus4.Addr = 16'h0011;
    #1 chk("odd_stall", 16'(bus4.Stall), 16'd0);
    cyc();
    chk("odd_err", 16'(bus4.err), 16'd1);
    chk("odd_done", 16'(bus4.Done), 16'd0);
    bus4.Rd = 1'b0;
    cyc();
    chk("odd_err_clear", 16'(bus4.err), 16'd0);
    chk("odd_no_done", 16'(bus4.Done), 16'd0);

    // Rd&Wr held two cycles: two err pulses, no access
    req4(1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0);
    bus4.Rd = 1'b1; bus4.Wr = 1'b1; bus4.Addr = 16'h0020; bus4.DataIn = 16'h9999;
    #1 chk("both_stall", 16'(bus4.Stall), 16'd0);
    cyc();
    chk("both_err_a", 16'(bus4.err), 16'd1);
    cyc();
    chk("both_err_b", 16'(bus4.err), 16'd1);
    bus4.Rd = 1'b0; bus4.Wr = 1'b0;
    cyc();
    chk("both_err_clear", 16'(bus4.err), 16'd0);
    chk("both_no_done", 16'(bus4.Done), 16'd0);
    req4(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

    // Aliasing with inputs scrambled during BUSY
    req4(1'b0, 1'b1, 16'h0202, 16'h1234, 1'b1);
    req4(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1);

    // Reset during BUSY abandons the write
    req4(1'b0, 1'b1, 16'h0040, 16'hAAAA, 1'b0);
    bus4.Wr = 1'b1; bus4.Addr = 16'h0040; bus4.DataIn = 16'h5555;
    cyc();
    cyc();
    #1 chk("abort_busy_stall", 16'(bus4.Stall), 16'd1);
    bus4.Wr = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_stall", 16'(bus4.Stall), 16'd0);
    chk("abort_done", 16'(bus4.Done), 16'd0);
    chk("abort_dout", bus4.DataOut, 16'h0000);
    last4 = 16'h0000;
    @(negedge clk) rst = 1'b0;
    cyc();
    req4(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);

    // LATENCY=1 back-to-back writes then reads
    b2b1(1'b1, 16'h0100);
    b2b1(1'b0, 16'h0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
